// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter register that issues fetch addresses over a valid/ready handshake
//   clk, rst_n        clock and asynchronous active-low reset
//   next_pc, pc_write next PC from the select mux and the advance enable (0 = stall)
//   imem_req_valid/imem_req_ready/imem_addr  fetch request to instruction memory
//   pc, pc_plus4      current PC and its sequential successor
//   misalign_err      sticky flag set when a misaligned next_pc is accepted
//   fetch_count       number of completed fetch handshakes
module pc_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] next_pc,
  input  logic                  pc_write,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  misalign_err,
  output logic [DATA_WIDTH-1:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] pc_nx, cnt_nx;
  logic err_nx, hs, adv, bad;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nx;
      pc           <= pc_nx;
      misalign_err <= err_nx;
      fetch_count  <= cnt_nx;
    end
  end
  // valid is a pure decode of the state register, so reset drops it at once
  assign imem_req_valid = state == FETCH;
  assign hs  = imem_req_valid && imem_req_ready;
  assign adv = hs && pc_write;
  assign bad = next_pc[1:0] != 2'b00;
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    err_nx   = misalign_err;
    cnt_nx   = fetch_count;
    state_nx = state == IDLE ? FETCH : (adv && bad) ? HALT : state;
    pc_nx    = (adv && !bad) ? next_pc : pc;
    err_nx   = misalign_err || (adv && bad);
    cnt_nx   = hs ? fetch_count + DATA_WIDTH'(1) : fetch_count;
  end
  assign imem_addr = pc;
  assign pc_plus4  = pc + DATA_WIDTH'(4);
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: table, directed and random checks of pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;
  logic clk = 0, rst_n = 0;
  logic [31:0] next_pc = 0;
  logic pc_write = 0, ready = 0;
  logic valid, err;
  logic [31:0] addr, pc, plus4, cnt;
  logic [3:0] np4 = 4'h0, addr4, pc4, plus4_4, cnt4;
  logic valid4, err4;
  int n_checks = 0, n_fail = 0;
  logic [31:0] m_pc, m_cnt;
  bit m_started, m_halt, m_err;

  pc_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc_write(pc_write),
    .imem_req_valid(valid), .imem_req_ready(ready), .imem_addr(addr),
    .pc(pc), .pc_plus4(plus4), .misalign_err(err), .fetch_count(cnt));

  // narrow instance keeps ready high and pc_write low so its counter wraps quickly
  pc_fetch_unit #(.DATA_WIDTH(4), .RESET_PC(4'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .next_pc(np4), .pc_write(1'b0),
    .imem_req_valid(valid4), .imem_req_ready(1'b1), .imem_addr(addr4),
    .pc(pc4), .pc_plus4(plus4_4), .misalign_err(err4), .fetch_count(cnt4));

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] np;
    logic pw, rdy;
    logic [31:0] e_addr;
    logic e_valid, e_err;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h100; m_cnt = 0; m_started = 0; m_halt = 0; m_err = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " pc"}, pc, m_pc);
    check({tag, " addr"}, addr, m_pc);
    check({tag, " pc_plus4"}, plus4, m_pc + 32'd4);
    check({tag, " valid"}, {31'b0, valid}, {31'b0, m_started && !m_halt});
    check({tag, " err"}, {31'b0, err}, {31'b0, m_err});
    check({tag, " count"}, cnt, m_cnt);
  endtask

  // called just after a falling edge; drives inputs, advances the model, checks after the next rising edge
  task automatic cyc(input logic [31:0] np, input logic pw, input logic rdy);
    next_pc = np; pc_write = pw; ready = rdy;
    if (m_started && !m_halt && rdy) begin
      m_cnt = m_cnt + 1;
      if (pw && np % 4 == 0) m_pc = np;
      else if (pw) begin m_err = 1; m_halt = 1; end
    end
    m_started = 1;
    @(posedge clk);
    @(negedge clk);
    check_model("cyc");
  endtask

  task automatic reset_dut();
    rst_n = 0;
    #1;
    model_reset();
    check("reset pc", pc, 32'h100);
    check("reset valid", {31'b0, valid}, 32'd0);
    check("reset err", {31'b0, err}, 32'd0);
    check("reset count", cnt, 32'd0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    vecs.push_back('{32'h104, 1, 1, 32'h100, 1, 0, 0});
    vecs.push_back('{32'h104, 1, 1, 32'h104, 1, 0, 1});
    vecs.push_back('{32'h108, 1, 1, 32'h108, 1, 0, 2});
    vecs.push_back('{32'h10C, 1, 1, 32'h10C, 1, 0, 3});
    vecs.push_back('{32'h110, 1, 1, 32'h110, 1, 0, 4});
    vecs.push_back('{32'h200, 1, 0, 32'h110, 1, 0, 4});
    vecs.push_back('{32'h200, 1, 0, 32'h110, 1, 0, 4});
    vecs.push_back('{32'h200, 1, 0, 32'h110, 1, 0, 4});
    vecs.push_back('{32'h200, 1, 1, 32'h200, 1, 0, 5});
    vecs.push_back('{32'h300, 0, 1, 32'h200, 1, 0, 6});
    vecs.push_back('{32'h300, 0, 1, 32'h200, 1, 0, 7});
    vecs.push_back('{32'h300, 1, 1, 32'h300, 1, 0, 8});
    vecs.push_back('{32'h302, 1, 1, 32'h300, 0, 1, 9});
    vecs.push_back('{32'h400, 1, 1, 32'h300, 0, 1, 9});
    vecs.push_back('{32'h404, 1, 0, 32'h300, 0, 1, 9});
    vecs.push_back('{32'h408, 0, 1, 32'h300, 0, 1, 9});

    #2;
    @(negedge clk);
    reset_dut();
    foreach (vecs[i]) begin
      cyc(vecs[i].np, vecs[i].pw, vecs[i].rdy);
      check($sformatf("vec%0d addr", i), addr, vecs[i].e_addr);
      check($sformatf("vec%0d plus4", i), plus4, vecs[i].e_addr + 32'd4);
      check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
      check($sformatf("vec%0d err", i), {31'b0, err}, {31'b0, vecs[i].e_err});
      check($sformatf("vec%0d count", i), cnt, vecs[i].e_cnt);
    end

    reset_dut();
    cyc(32'h0, 1, 0);
    cyc(32'hFFFF_FFFC, 1, 1);
    check("wrap pc", pc, 32'hFFFF_FFFC);
    check("wrap pc_plus4", plus4, 32'h0);
    cyc(32'h0, 1, 0);
    check("pending valid", {31'b0, valid}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    check("async reset valid", {31'b0, valid}, 32'd0);
    check("async reset pc", pc, 32'h100);
    check("async reset count", cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 16; i++) cyc(32'h0, 0, 0);
    check("narrow count before wrap", {28'b0, cnt4}, 32'hF);
    cyc(32'h0, 0, 0);
    check("narrow count wrap", {28'b0, cnt4}, 32'h0);

    reset_dut();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] np;
      np = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 15) == 0) np[1:0] = 2'($urandom_range(1, 3));
      if (m_halt && $urandom_range(0, 7) == 0) reset_dut();
      else cyc(np, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
